// File: rtl/mac_ctrl_pkg.sv
// Shared constants and width helpers for the FC-layer MAC sequencer.
// State encodings are plain 2-bit constants so legacy code can compare against them directly.
package mac_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Lane contract: product lands MAC_PIPE_LAT after mac_en; clear/result CLR_OFFSET after last mac_en.
    localparam int MAC_PIPE_LAT = 2;
    localparam int CLR_OFFSET   = 3;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_ctrl_dly.sv
// Fixed-depth shift register with synchronous active-high flush.
module mac_ctrl_dly #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    // NOTE: this small array is reset on purpose -- a stale strobe left in it would fire after an abort.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/mac_seq_ctrl.sv
// Address/strobe sequencer for the FC-layer MAC bank; group tails overlap the next group's reads.
// Define MAC_SEQ_STALL_EN to add in_ready_i, which holds the read stream while low.
module mac_seq_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int IN_LEN     = 784,
    parameter int NUM_GROUPS = 8,
    parameter int RD_LAT     = 1,
    localparam int IMG_W = cnt_w(IN_LEN),
    localparam int WGT_W = cnt_w(IN_LEN * NUM_GROUPS),
    localparam int GRP_W = cnt_w(NUM_GROUPS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
`ifdef MAC_SEQ_STALL_EN
    input  logic             in_ready_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic             rd_en_o,
    output logic [IMG_W-1:0] img_addr_o,
    output logic [WGT_W-1:0] wgt_addr_o,
    output logic             mac_en_o,
    output logic             mac_valid_o,
    output logic             mac_clear_o,
    output logic             res_valid_o,
    output logic [GRP_W-1:0] res_group_o
);

    logic [1:0]       state_q, state_d;
    logic [IMG_W-1:0] k_q, k_d;
    logic [GRP_W-1:0] g_q, g_d;
    logic [WGT_W-1:0] base_q, base_d;
    logic             advance;
    logic             last_k, last_g, last_beat;
    logic [GRP_W:0]   mark_in, mark_vld, mark_res;

`ifdef MAC_SEQ_STALL_EN
    assign advance = in_ready_i;
`else
    assign advance = 1'b1;
`endif

    assign last_k    = (k_q == IMG_W'(IN_LEN - 1));
    assign last_g    = (g_q == GRP_W'(NUM_GROUPS - 1));
    assign rd_en_o   = (state_q == ST_RUN) && advance;
    assign last_beat = rd_en_o && last_k;
    assign busy_o    = (state_q != ST_IDLE);

    // Weight base steps by IN_LEN per group, so no multiplier sits on the address path.
    assign img_addr_o = k_q;
    assign wgt_addr_o = base_q + WGT_W'(k_q);

    // NOTE: every next-state signal gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        g_d     = g_q;
        base_d  = base_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    k_d     = '0;
                    g_d     = '0;
                    base_d  = '0;
                end
            end
            ST_RUN: begin
                if (advance) begin
                    if (last_k) begin
                        k_d = '0;
                        if (last_g) begin
                            state_d = ST_DRAIN;
                            g_d     = '0;
                            base_d  = '0;
                        end else begin
                            state_d = ST_GAP;
                            g_d     = g_q + GRP_W'(1);
                            base_d  = base_q + WGT_W'(IN_LEN);
                        end
                    end else begin
                        k_d = k_q + IMG_W'(1);
                    end
                end
            end
            ST_GAP: state_d = ST_RUN;
            ST_DRAIN: begin
                if (done_o) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            g_q     <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            g_q     <= g_d;
            base_q  <= base_d;
        end
    end

    mac_ctrl_dly #(.WIDTH(1), .DEPTH(RD_LAT)) u_en_dly (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (rd_en_o),
        .q_o   (mac_en_o)
    );

    // The group index rides with the last-beat marker, so tails stay correct while g_q moves on.
    assign mark_in = {last_beat, g_q};

    mac_ctrl_dly #(.WIDTH(GRP_W + 1), .DEPTH(RD_LAT + CLR_OFFSET - MAC_PIPE_LAT)) u_vld_dly (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (mark_in),
        .q_o   (mark_vld)
    );

    mac_ctrl_dly #(.WIDTH(GRP_W + 1), .DEPTH(MAC_PIPE_LAT)) u_res_dly (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (mark_vld),
        .q_o   (mark_res)
    );

    assign mac_valid_o = mark_vld[GRP_W];
    assign res_valid_o = mark_res[GRP_W];
    assign mac_clear_o = mark_res[GRP_W];
    assign res_group_o = mark_res[GRP_W-1:0];
    assign done_o      = res_valid_o && (state_q == ST_DRAIN)
                         && (res_group_o == GRP_W'(NUM_GROUPS - 1));

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench: timing model per cycle plus a MAC-lane scoreboard for the main instance.
module tb_mac_seq_ctrl;
    import mac_ctrl_pkg::*;

    localparam int IL = 4;
    localparam int NG = 2;
    localparam int A  = 5;
    localparam int B  = A + 30;
    localparam int C  = B + 10;
`ifdef MAC_SEQ_STALL_EN
    localparam int D       = C + 16;
    localparam int END_CYC = D + 18;
`else
    localparam int END_CYC = C + 17;
`endif

    typedef struct {
        bit rd, mac, vld, res, done, busy;
        int img, wgt, grp;
    } exp_t;

    typedef struct {
        int cyc;
        int grp;
        int val;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic in_ready = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    sb_t  sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // main instance: IN_LEN=4, NUM_GROUPS=2, RD_LAT=1
    logic busy0, done0, rd0, mac0, vld0, clr0, res0;
    logic [1:0] img0;
    logic [2:0] wgt0;
    logic [0:0] grp0;
    // RD_LAT=3
    logic busy3, done3, rd3, mac3, vld3, clr3, res3;
    logic [1:0] img3;
    logic [2:0] wgt3;
    logic [0:0] grp3;
    // NUM_GROUPS=1
    logic busy1, done1, rd1, mac1, vld1, clr1, res1;
    logic [1:0] img1;
    logic [1:0] wgt1;
    logic [0:0] grp1;

    mac_seq_ctrl #(.IN_LEN(IL), .NUM_GROUPS(NG), .RD_LAT(1)) u0 (
        .clk_i(clk), .rst_i(rst), .start_i(start),
`ifdef MAC_SEQ_STALL_EN
        .in_ready_i(in_ready),
`endif
        .busy_o(busy0), .done_o(done0), .rd_en_o(rd0), .img_addr_o(img0), .wgt_addr_o(wgt0),
        .mac_en_o(mac0), .mac_valid_o(vld0), .mac_clear_o(clr0), .res_valid_o(res0), .res_group_o(grp0)
    );

    mac_seq_ctrl #(.IN_LEN(IL), .NUM_GROUPS(NG), .RD_LAT(3)) u_lat3 (
        .clk_i(clk), .rst_i(rst), .start_i(start),
`ifdef MAC_SEQ_STALL_EN
        .in_ready_i(in_ready),
`endif
        .busy_o(busy3), .done_o(done3), .rd_en_o(rd3), .img_addr_o(img3), .wgt_addr_o(wgt3),
        .mac_en_o(mac3), .mac_valid_o(vld3), .mac_clear_o(clr3), .res_valid_o(res3), .res_group_o(grp3)
    );

    mac_seq_ctrl #(.IN_LEN(IL), .NUM_GROUPS(1), .RD_LAT(1)) u_g1 (
        .clk_i(clk), .rst_i(rst), .start_i(start),
`ifdef MAC_SEQ_STALL_EN
        .in_ready_i(in_ready),
`endif
        .busy_o(busy1), .done_o(done1), .rd_en_o(rd1), .img_addr_o(img1), .wgt_addr_o(wgt1),
        .mac_en_o(mac1), .mac_valid_o(vld1), .mac_clear_o(clr1), .res_valid_o(res1), .res_group_o(grp1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference timing for a layer whose start_i was high in cycle 0 (c<0 means idle/zero).
    function automatic exp_t exp_at(input int il, input int ng, input int rl, input int c);
        exp_t e;
        int per, dc, cm, lst;
        e   = '{default: 0};
        per = il + 1;
        dc  = ng * per + rl + 2;
        cm  = c - rl;
        if (c >= 1 && c <= ng * per - 1 && (c - 1) % per != il) begin
            e.rd  = 1'b1;
            e.img = (c - 1) % per;
            e.wgt = ((c - 1) / per) * il + (c - 1) % per;
        end
        e.mac = (cm >= 1 && cm <= ng * per - 1 && (cm - 1) % per != il);
        for (int g = 0; g < ng; g++) begin
            lst = g * per + il + rl;
            if (c == lst + 1) e.vld = 1'b1;
            if (c == lst + 3) begin
                e.res = 1'b1;
                e.grp = g;
            end
        end
        e.done = (c == dc);
        e.busy = (c >= 1 && c <= dc);
        return e;
    endfunction

    function automatic logic [31:0] ctl_of(input exp_t e);
        return 32'({e.rd, e.mac, e.vld, e.res, e.res, e.done, e.busy});
    endfunction

    task automatic push_layer(input int base, input int extra);
        for (int g = 0; g < NG; g++)
            sb.push_back('{base + g * (IL + 1) + IL + 1 + 3 + extra, g, 10 * (g + 1)});
    endtask

    // MAC lane model: image[k]=k+1, weight = group+1; product of mac_en(t) lands at end of t+2.
    logic s_rd = 1'b0, s_mac = 1'b0, s_clr = 1'b0;
    logic [1:0] s_img = '0;
    logic [2:0] s_wgt = '0;
    int dat = 0, p1 = 0, p2 = 0, acc = 0;
    logic [1:0] mac_hist = '0;

    always @(negedge clk) begin
        s_rd  <= rd0;
        s_mac <= mac0;
        s_clr <= clr0;
        s_img <= img0;
        s_wgt <= wgt0;
    end

    always @(posedge clk) begin
        if (rst) begin
            dat <= 0;
            p1  <= 0;
            p2  <= 0;
            acc <= 0;
        end else begin
            dat <= s_rd ? (32'(s_img) + 1) * (32'(s_wgt) / IL + 1) : 0;
            p1  <= s_mac ? dat : 0;
            p2  <= p1;
            acc <= s_clr ? 0 : acc + p2;
        end
    end

    always @(negedge clk) begin
        int c, c3, c1, cd;
        bit zero_win, stall_win;
        exp_t e;
        sb_t  top;
        if (cyc >= 1 && cyc < END_CYC) begin
            zero_win = (cyc < A) || (cyc >= B + 8 && cyc < C);
            if (cyc < A)           c = -1;
            else if (cyc < A + 14) c = cyc - A;
            else if (cyc < B)      c = cyc - (A + 14);
            else if (cyc < B + 8)  c = cyc - B;
            else if (cyc < C)      c = -1;
            else                   c = cyc - C;
            stall_win = 1'b0;
`ifdef MAC_SEQ_STALL_EN
            stall_win = (cyc >= D);
            if (stall_win) begin
                cd = cyc - D;
                if (cd <= 8) begin
                    check($sformatf("stall_rd@%0d", cd), 32'(rd0), 32'(cd == 1 || (cd >= 4 && cd <= 6)));
                    if (cd == 1 || (cd >= 4 && cd <= 6))
                        check($sformatf("stall_wgt@%0d", cd), 32'(wgt0), (cd == 1) ? 0 : cd - 3);
                    check($sformatf("stall_mac@%0d", cd), 32'(mac0), 32'(cd == 2 || (cd >= 5 && cd <= 7)));
                    check($sformatf("stall_vld@%0d", cd), 32'(vld0), 32'(cd == 8));
                end else begin
                    check($sformatf("stall_done@%0d", cd), 32'(done0), 32'(cd == 15));
                end
            end
`endif
            if (!stall_win) begin
                e = exp_at(IL, NG, 1, c);
                check($sformatf("u0_ctl@%0d", cyc),
                      32'({rd0, mac0, vld0, res0, clr0, done0, busy0}), ctl_of(e));
                if (e.rd || zero_win) begin
                    check($sformatf("u0_img@%0d", cyc), 32'(img0), e.img);
                    check($sformatf("u0_wgt@%0d", cyc), 32'(wgt0), e.wgt);
                end
                if (e.res || zero_win)
                    check($sformatf("u0_grp@%0d", cyc), 32'(grp0), e.grp);
            end
            if (cyc < A + 17) begin
                c3 = (cyc < A) ? -1 : cyc - A;
                check($sformatf("lat3_ctl@%0d", cyc),
                      32'({rd3, mac3, vld3, res3, clr3, done3, busy3}), ctl_of(exp_at(IL, NG, 3, c3)));
            end
            if (cyc < A + 13) begin
                c1 = (cyc < A) ? -1 : cyc - A;
                check($sformatf("g1_ctl@%0d", cyc),
                      32'({rd1, mac1, vld1, res1, clr1, done1, busy1}), ctl_of(exp_at(IL, 1, 1, c1)));
            end
            if (clr0) check($sformatf("clr_hazard@%0d", cyc), 32'(mac_hist[1]), 0);
            if (vld0) check($sformatf("vld_hazard@%0d", cyc), 32'(mac0), 0);
            if (res0) begin
                if (sb.size() == 0) begin
                    check($sformatf("sb_unexpected@%0d", cyc), 32'(res0), 0);
                end else begin
                    top = sb.pop_front();
                    check($sformatf("sb_cyc@%0d", cyc), cyc, top.cyc);
                    check($sformatf("sb_grp@%0d", cyc), 32'(grp0), top.grp);
                    check($sformatf("sb_acc@%0d", cyc), acc, top.val);
                end
            end
        end
        mac_hist <= {mac_hist[0], mac0};
    end

    initial begin
        int n;
        forever begin
            @(posedge clk);
            #1;
            n = cyc;
            if (n >= END_CYC) break;
            rst   = (n < 3) || (n == B + 7);
            start = (n == A) || (n == A + 5) || (n == A + 13) || (n == A + 14) || (n == B) || (n == C);
            if (n == A || n == A + 14 || n == B || n == C) push_layer(n, 0);
            if (n == B + 7) sb.delete();
`ifdef MAC_SEQ_STALL_EN
            if (n == D) begin
                start = 1'b1;
                push_layer(n, 2);
            end
            in_ready = !(n == D + 2 || n == D + 3);
`endif
        end
        check("sb_left", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
